pc_gen_unit: RTL and testbench
==============================

Name: pc_gen_unit

Overview:
Parametrised next-generation program counter unit. It generates the fetch PC and presents it to instruction fetch through a valid/ready handshake. Next-PC selection is prioritised: trap, then misaligned-redirect trap, then branch/jump redirect, then return-address-stack (RAS) return prediction, then sequential increment. It sits between the execute-stage redirect logic and the instruction memory interface. It replaces the fixed increment/immediate mux arrangement.

Parameters:
DWIDTH, 32, PC and data width in bits
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
TRAP_VECTOR, 32'h0000_0100, PC value loaded on any trap
INC, 4, sequential increment in bytes (power of two, ≥2)
RAS_DEPTH, 4, return address stack entries (power of two, ≥2)

Ports:
Clk_Core  in  1  core clock
Rst_Core  in  1  asynchronous reset, active-high
Run  in  1  enable; 0 holds PC and deasserts Fetch_Valid
Fetch_Ready  in  1  fetch accepts current PC
Fetch_Valid  out  1  Program_Count valid for fetch
Program_Count  out  DWIDTH  current fetch PC
Program_Count_Off  out  DWIDTH  Program_Count + INC, combinational
Redirect_Valid  in  1  branch/jump taken this cycle
Redirect_Target  in  DWIDTH  redirect destination
Trap_Req  in  1  external exception/interrupt request
Call_Hint  in  1  fetched instruction is a call; qualified by handshake
Ret_Hint  in  1  fetched instruction is a return; qualified by handshake
Trap_Taken  out  1  one-cycle pulse, registered, trap accepted
Trap_Pc  out  DWIDTH  PC captured at last trap
Misaligned  out  1  one-cycle pulse, registered, misaligned redirect seen
Ras_Count  out  $clog2(RAS_DEPTH)+1  valid RAS entries

Behaviour:
- Reset (async, Rst_Core=1) sets the following, regardless of state or any in-flight operation:
  - Program_Count=RESET_VECTOR, state=IDLE, Fetch_Valid=0.
  - Trap_Taken=0, Misaligned=0, Trap_Pc=0, Ras_Count=0, RAS pointer=0.
- States:
  - IDLE: Fetch_Valid=0; PC held; all inputs except Run are ignored. Run=1 moves to ACTIVE next cycle.
  - ACTIVE: Fetch_Valid=Run. Run=0 moves to IDLE next cycle with PC held.
- Accept = Fetch_Valid & Fetch_Ready.
- Next-PC in ACTIVE, evaluated each cycle in priority order; the first true term wins:
  1. Trap_Req: PC←TRAP_VECTOR; Trap_Pc←Program_Count; Trap_Taken=1 next cycle; RAS cleared (Ras_Count←0).
  2. Redirect_Valid with Redirect_Target[$clog2(INC)-1:0]≠0: PC←TRAP_VECTOR; Trap_Pc←Redirect_Target; Misaligned=1 and Trap_Taken=1 next cycle; RAS cleared.
  3. Redirect_Valid (aligned): PC←Redirect_Target; RAS unchanged. Applies even when Accept=0.
  4. Accept & Ret_Hint & Ras_Count>0: PC←RAS top; pop.
  5. Accept: PC←Program_Count+INC. This includes Ret_Hint with an empty RAS.
  6. Otherwise PC held (stall).
- Call_Hint on Accept pushes Program_Count+INC. This applies only when selection falls to step 4 or 5; redirects and traps suppress the push.
- Ret_Hint and Call_Hint together on Accept: pop, then push. The top entry is replaced by PC+INC; PC←old top; Ras_Count unchanged.
- RAS is circular:
  - Push when full overwrites the oldest entry; Ras_Count saturates at RAS_DEPTH.
  - Pop when empty is a no-op.
- Arithmetic is modulo 2^DWIDTH: PC+INC wraps from all-ones-minus-INC+1 to 0 with no flag.
- Trap_Taken and Misaligned are single-cycle pulses. Back-to-back traps pulse on consecutive cycles.
- Latency: any PC change is visible on Program_Count the cycle after the causing event. Program_Count is driven directly from a register.

Test Plan:
- Reset then Run=1, Fetch_Ready=1 for 4 cycles → Fetch_Valid rises 1 cycle after Run; PC sequence 0x0, 0x4, 0x8, 0xC.
- At PC=0x8, Fetch_Ready=0 for 3 cycles, then Redirect_Valid=1, Target=0x40 while still stalled → PC holds 0x8 for the stall cycles, then 0x40 the cycle after the redirect.
- Call_Hint at PC=0x10 with Accept, redirect to 0x80, then Ret_Hint at 0x84 with Accept → Ras_Count 1 after the call, PC 0x14 after the return, Ras_Count 0.
- RAS_DEPTH=4: five calls from PCs 0x0, 0x10, 0x20, 0x30, 0x40 (redirecting between them), then five returns → Ras_Count saturates at 4; returns go to 0x44, 0x34, 0x24, 0x14; the fifth return falls through to PC+4.
- Redirect_Valid with Target=0x102 → next cycle PC=0x100, Misaligned=1, Trap_Taken=1, Trap_Pc=0x102, Ras_Count=0.
- Trap_Req and Redirect_Valid together at PC=0x20 → PC=TRAP_VECTOR, Trap_Pc=0x20. Then assert Rst_Core mid-cycle → Program_Count=0 and Fetch_Valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pc_gen_unit.sv
// pc_gen_unit: fetch program counter generator with a valid/ready fetch
// handshake, prioritised next-PC selection and a circular return address stack.
//
// Ports:
//   Clk_Core, Rst_Core          clock, asynchronous active-high reset
//   Run                         enable; low holds the PC and drops Fetch_Valid
//   Fetch_Ready / Fetch_Valid   fetch handshake for Program_Count
//   Program_Count(_Off)         current fetch PC and PC+INC
//   Redirect_Valid/_Target      taken branch/jump from execute
//   Trap_Req                    exception/interrupt request
//   Call_Hint / Ret_Hint        call/return hints, qualified by the handshake
//   Trap_Taken / Misaligned     registered single-cycle pulses
//   Trap_Pc                     PC (or bad target) captured at the last trap
//   Ras_Count                   number of valid RAS entries
module pc_gen_unit #(
  parameter int unsigned       DWIDTH       = 32,
  parameter logic [DWIDTH-1:0] RESET_VECTOR = DWIDTH'(32'h0000_0000),
  parameter logic [DWIDTH-1:0] TRAP_VECTOR  = DWIDTH'(32'h0000_0100),
  parameter int unsigned       INC          = 4,
  parameter int unsigned       RAS_DEPTH    = 4
) (
  input  logic                           Clk_Core,
  input  logic                           Rst_Core,
  input  logic                           Run,
  input  logic                           Fetch_Ready,
  output logic                           Fetch_Valid,
  output logic [DWIDTH-1:0]              Program_Count,
  output logic [DWIDTH-1:0]              Program_Count_Off,
  input  logic                           Redirect_Valid,
  input  logic [DWIDTH-1:0]              Redirect_Target,
  input  logic                           Trap_Req,
  input  logic                           Call_Hint,
  input  logic                           Ret_Hint,
  output logic                           Trap_Taken,
  output logic [DWIDTH-1:0]              Trap_Pc,
  output logic                           Misaligned,
  output logic [$clog2(RAS_DEPTH):0]     Ras_Count
);

  localparam int unsigned PTR_W   = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned ALIGN_W = $clog2(INC);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                  state_q, state_d;
  logic [DWIDTH-1:0]       pc_q, pc_d;
  logic [DWIDTH-1:0]       trap_pc_q, trap_pc_d;
  logic                    trap_taken_q, trap_taken_d;
  logic                    misaligned_q, misaligned_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [DWIDTH-1:0]       ras_q [RAS_DEPTH];

  logic                    ras_we;
  logic [PTR_W-1:0]        ras_waddr;
  logic [PTR_W-1:0]        top_idx;
  logic                    do_pop;
  logic                    accept;
  logic [DWIDTH-1:0]       pc_inc;

  assign pc_inc            = pc_q + DWIDTH'(INC);
  assign Fetch_Valid       = (state_q == ACTIVE) && Run;
  assign accept            = Fetch_Valid && Fetch_Ready;
  assign Program_Count     = pc_q;
  assign Program_Count_Off = pc_inc;
  assign Trap_Pc           = trap_pc_q;
  assign Trap_Taken        = trap_taken_q;
  assign Misaligned        = misaligned_q;
  assign Ras_Count         = cnt_q;

  // ptr_q points at the next free slot, so the top entry sits one below it.
  assign top_idx = ptr_q - PTR_W'(1);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    trap_pc_d    = trap_pc_q;
    trap_taken_d = 1'b0;
    misaligned_d = 1'b0;
    cnt_d        = cnt_q;
    ptr_d        = ptr_q;
    ras_we       = 1'b0;
    ras_waddr    = ptr_q;
    do_pop       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (Run) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (!Run) begin
          state_d = IDLE;
        end else if (Trap_Req) begin
          pc_d         = TRAP_VECTOR;
          trap_pc_d    = pc_q;
          trap_taken_d = 1'b1;
          cnt_d        = '0;
          ptr_d        = '0;
        end else if (Redirect_Valid &&
                     (Redirect_Target[ALIGN_W-1:0] != '0)) begin
          pc_d         = TRAP_VECTOR;
          trap_pc_d    = Redirect_Target;
          trap_taken_d = 1'b1;
          misaligned_d = 1'b1;
          cnt_d        = '0;
          ptr_d        = '0;
        end else if (Redirect_Valid) begin
          pc_d = Redirect_Target;
        end else if (accept) begin
          do_pop = Ret_Hint && (cnt_q != '0);
          pc_d   = do_pop ? ras_q[top_idx] : pc_inc;
          if (Call_Hint) begin
            ras_we = 1'b1;
            if (do_pop) begin
              // pop+push collapses to overwriting the top in place
              ras_waddr = top_idx;
            end else begin
              // full stack wraps onto the oldest entry; count saturates
              ptr_d = ptr_q + PTR_W'(1);
              if (cnt_q != CNT_W'(RAS_DEPTH)) cnt_d = cnt_q + CNT_W'(1);
            end
          end else if (do_pop) begin
            ptr_d = top_idx;
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk_Core or posedge Rst_Core) begin
    if (Rst_Core) begin
      state_q      <= IDLE;
      pc_q         <= RESET_VECTOR;
      trap_pc_q    <= '0;
      trap_taken_q <= 1'b0;
      misaligned_q <= 1'b0;
      cnt_q        <= '0;
      ptr_q        <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      trap_pc_q    <= trap_pc_d;
      trap_taken_q <= trap_taken_d;
      misaligned_q <= misaligned_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
    end
  end

  // Entries are only readable below ptr_q/cnt_q, so storage needs no reset.
  always_ff @(posedge Clk_Core) begin
    if (ras_we) ras_q[ras_waddr] <= pc_inc;
  end

endmodule

// File: tb/tb_pc_gen_unit.sv
module tb_pc_gen_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        run, rdy, fv;
  logic [31:0] pc, pc_off, tgt, trap_pc;
  logic        rv, trap_req, call_h, ret_h, trap_taken, mis;
  logic [2:0]  ras_cnt;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  pc_gen_unit #(
    .DWIDTH      (32),
    .RESET_VECTOR(32'h0000_0000),
    .TRAP_VECTOR (32'h0000_0100),
    .INC         (4),
    .RAS_DEPTH   (4)
  ) dut (
    .Clk_Core         (clk),
    .Rst_Core         (rst),
    .Run              (run),
    .Fetch_Ready      (rdy),
    .Fetch_Valid      (fv),
    .Program_Count    (pc),
    .Program_Count_Off(pc_off),
    .Redirect_Valid   (rv),
    .Redirect_Target  (tgt),
    .Trap_Req         (trap_req),
    .Call_Hint        (call_h),
    .Ret_Hint         (ret_h),
    .Trap_Taken       (trap_taken),
    .Trap_Pc          (trap_pc),
    .Misaligned       (mis),
    .Ras_Count        (ras_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] t);
    rv = 1'b1; tgt = t;
    tick();
    rv = 1'b0;
  endtask

  logic [31:0] ret_exp [5];

  initial begin
    rst = 1'b1; run = 1'b0; rdy = 1'b0; rv = 1'b0; tgt = '0;
    trap_req = 1'b0; call_h = 1'b0; ret_h = 1'b0;
    #3;
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_fv", {31'b0, fv}, 32'h0);
    check_eq("rst_ras", {29'b0, ras_cnt}, 32'h0);
    check_eq("rst_trap_pc", trap_pc, 32'h0);
    check_eq("rst_tt", {31'b0, trap_taken}, 32'h0);
    check_eq("rst_mis", {31'b0, mis}, 32'h0);
    tick();
    rst = 1'b0;

    // Sequential fetch: Fetch_Valid one cycle after Run
    run = 1'b1; rdy = 1'b1;
    #1 check_eq("fv_idle", {31'b0, fv}, 32'h0);
    tick();
    check_eq("fv_up", {31'b0, fv}, 32'h1);
    check_eq("seq0", pc, 32'h0);
    tick(); check_eq("seq4", pc, 32'h4);
    tick(); check_eq("seq8", pc, 32'h8);
    check_eq("off8", pc_off, 32'hC);

    // Stall at 0x8, then redirect while still stalled
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); check_eq("stall8", pc, 32'h8);
    end
    redirect(32'h40);
    check_eq("redir40", pc, 32'h40);

    // Call at 0x10, redirect away, return at 0x84
    redirect(32'h10);
    rdy = 1'b1; call_h = 1'b1;
    tick(); call_h = 1'b0;
    check_eq("call_pc", pc, 32'h14);
    check_eq("call_cnt", {29'b0, ras_cnt}, 32'h1);
    redirect(32'h84);
    check_eq("redir84", pc, 32'h84);
    ret_h = 1'b1;
    tick(); ret_h = 1'b0;
    check_eq("ret_pc", pc, 32'h14);
    check_eq("ret_cnt", {29'b0, ras_cnt}, 32'h0);

    // Five calls into a 4-deep RAS, then five returns
    for (int i = 0; i < 5; i++) begin
      redirect(32'(i * 16));
      call_h = 1'b1;
      tick(); call_h = 1'b0;
      check_eq("call5_pc", pc, 32'(i * 16 + 4));
      check_eq("call5_cnt", {29'b0, ras_cnt}, (i < 4) ? 32'(i + 1) : 32'h4);
    end
    ret_exp[0] = 32'h44; ret_exp[1] = 32'h34; ret_exp[2] = 32'h24;
    ret_exp[3] = 32'h14; ret_exp[4] = 32'h18;
    ret_h = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("ret5_pc", pc, ret_exp[i]);
      check_eq("ret5_cnt", {29'b0, ras_cnt}, (i < 4) ? 32'(3 - i) : 32'h0);
    end
    ret_h = 1'b0;

    // Combined call+return replaces the top entry
    call_h = 1'b1;
    tick();
    check_eq("cr_push_pc", pc, 32'h1C);
    ret_h = 1'b1;
    tick(); call_h = 1'b0;
    check_eq("cr_pc", pc, 32'h1C);
    check_eq("cr_cnt", {29'b0, ras_cnt}, 32'h1);
    tick(); ret_h = 1'b0;
    check_eq("cr_ret_pc", pc, 32'h20);
    check_eq("cr_ret_cnt", {29'b0, ras_cnt}, 32'h0);

    // Misaligned redirect with a non-empty RAS
    call_h = 1'b1;
    tick(); call_h = 1'b0;
    check_eq("mis_pre_cnt", {29'b0, ras_cnt}, 32'h1);
    redirect(32'h102);
    check_eq("mis_pc", pc, 32'h100);
    check_eq("mis_flag", {31'b0, mis}, 32'h1);
    check_eq("mis_tt", {31'b0, trap_taken}, 32'h1);
    check_eq("mis_trap_pc", trap_pc, 32'h102);
    check_eq("mis_cnt", {29'b0, ras_cnt}, 32'h0);
    tick();
    check_eq("mis_pulse", {31'b0, mis}, 32'h0);
    check_eq("tt_pulse", {31'b0, trap_taken}, 32'h0);
    check_eq("mis_after_pc", pc, 32'h104);

    // PC wraps modulo 2^32
    redirect(32'hFFFF_FFFC);
    check_eq("wrap_off", pc_off, 32'h0);
    tick();
    check_eq("wrap_pc", pc, 32'h0);

    // Trap beats redirect; back-to-back traps pulse each cycle
    redirect(32'h20);
    trap_req = 1'b1; rv = 1'b1; tgt = 32'h80;
    tick(); rv = 1'b0;
    check_eq("trap_pc", pc, 32'h100);
    check_eq("trap_cap", trap_pc, 32'h20);
    check_eq("trap_tt", {31'b0, trap_taken}, 32'h1);
    check_eq("trap_mis", {31'b0, mis}, 32'h0);
    tick(); trap_req = 1'b0;
    check_eq("trap2_tt", {31'b0, trap_taken}, 32'h1);
    check_eq("trap2_cap", trap_pc, 32'h100);

    // Run low holds the PC and drops Fetch_Valid at once
    run = 1'b0;
    #1 check_eq("run0_fv", {31'b0, fv}, 32'h0);
    tick();
    check_eq("run0_pc", pc, 32'h100);
    run = 1'b1;
    tick();
    check_eq("run1_pc", pc, 32'h100);
    check_eq("run1_fv", {31'b0, fv}, 32'h1);

    // Asynchronous reset in mid-cycle
    #2 rst = 1'b1;
    #1;
    check_eq("async_pc", pc, 32'h0);
    check_eq("async_fv", {31'b0, fv}, 32'h0);
    check_eq("async_trap_pc", trap_pc, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
